witf_scoreboard: RTL and testbench

- Write-in-flight tracker for the in-order RV64 pipeline.
- ID pushes the destination register of each issued register-writing instruction.
- WB pops the oldest entry when it retires a write to a nonzero rd.
- Block answers RAW-hazard queries for the rs1/rs2 of the instruction in ID and raises a stall.
- Producer/query side of the witf interface; WB holds the pop side.

---
 rtl/witf_scoreboard_pkg.sv | 8 +
 rtl/witf_match.sv | 22 ++
 rtl/witf_scoreboard.sv | 113 +++++++++++
 tb/tb_witf_scoreboard.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/witf_scoreboard_pkg.sv
// Shared sizing for the write-in-flight tracker.
package witf_scoreboard_pkg;

    localparam int unsigned WitfDepth = 4;  // in-flight entries, power of 2
    localparam int unsigned RegAddrW  = 5;  // register address width (RegAddrBus)
    localparam int unsigned WitfPw    = 2;  // log2(WitfDepth)

endpackage

// File: rtl/witf_match.sv
// Combinational compare of one source register against every valid in-flight rd.
module witf_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5
) (
    input  logic [DEPTH*AW-1:0] entries,
    input  logic [DEPTH-1:0]    valid,
    input  logic [AW-1:0]       rs,
    output logic                hit_c
);

    // Any valid entry holding rs is a hit
    always_comb begin
        hit_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i*AW +: AW] == rs)) begin
                hit_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/witf_scoreboard.sv
// Write-in-flight tracker: ID pushes issued rd values, WB pops the oldest,
// and rs1/rs2 of the instruction in ID are checked for RAW hazards.
module witf_scoreboard
    import witf_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = WitfDepth,
    parameter int unsigned AW    = RegAddrW,
    parameter int unsigned PW    = WitfPw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_en,
    input  logic [AW-1:0] push_rd,
    input  logic          pop_en,
    input  logic          flush,
    input  logic [AW-1:0] rs1,
    input  logic          rs1_used,
    input  logic [AW-1:0] rs2,
    input  logic          rs2_used,
    output logic          raw_stall,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count,
    output logic          err
);

    logic [DEPTH-1:0][AW-1:0] entries;
    logic [DEPTH-1:0]         validBits;
    logic [PW-1:0]            headPtr;
    logic [PW-1:0]            tailPtr;
    logic [PW:0]              countReg;
    logic                     errReg;

    logic isFull;
    logic isEmpty;
    logic pushReq;
    logic doPush;
    logic doPop;
    logic protoErr;
    logic rs1Hit;
    logic rs2Hit;

    // Push/pop qualification and protocol error detection
    always_comb begin
        isFull   = (countReg == (PW+1)'(DEPTH));
        isEmpty  = (countReg == '0);
        pushReq  = push_en && (push_rd != '0);
        // A pop while full frees the slot at the same edge, so the push may proceed
        doPush   = pushReq && (!isFull || pop_en);
        doPop    = pop_en && !isEmpty;
        protoErr = (pushReq && isFull && !pop_en) || (pop_en && isEmpty);
    end

    // rd storage; contents are only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        if (doPush && !flush) begin
            entries[tailPtr] <= push_rd;
        end
    end

    // Valid bits, pointers, occupancy and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            validBits <= '0;
            headPtr   <= '0;
            tailPtr   <= '0;
            countReg  <= '0;
            errReg    <= 1'b0;
        end else if (flush) begin
            validBits <= '0;
            headPtr   <= '0;
            tailPtr   <= '0;
            countReg  <= '0;
        end else begin
            // Pop clears before push sets, so a full swap at head==tail stays valid
            if (doPop) begin
                validBits[headPtr] <= 1'b0;
                headPtr            <= headPtr + PW'(1);
            end
            if (doPush) begin
                validBits[tailPtr] <= 1'b1;
                tailPtr            <= tailPtr + PW'(1);
            end
            countReg <= countReg + (PW+1)'(doPush) - (PW+1)'(doPop);
            if (protoErr) begin
                errReg <= 1'b1;
            end
        end
    end

    witf_match #(.DEPTH(DEPTH), .AW(AW)) uMatchRs1 (
        .entries (entries),
        .valid   (validBits),
        .rs      (rs1),
        .hit_c   (rs1Hit)
    );

    witf_match #(.DEPTH(DEPTH), .AW(AW)) uMatchRs2 (
        .entries (entries),
        .valid   (validBits),
        .rs      (rs2),
        .hit_c   (rs2Hit)
    );

    // Stall from registered state only; no WB-to-ID bypass for the entry being popped
    assign raw_stall = (rs1_used && (rs1 != '0) && rs1Hit) ||
                       (rs2_used && (rs2 != '0) && rs2Hit);
    assign full      = isFull;
    assign empty     = isEmpty;
    assign count     = countReg;
    assign err       = errReg;

endmodule

// File: tb/tb_witf_scoreboard.sv
// Directed bench for witf_scoreboard with an expectation queue and a negedge monitor.
module tb_witf_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       push_en;
    logic [4:0] push_rd;
    logic       pop_en;
    logic       flush;
    logic [4:0] rs1;
    logic       rs1_used;
    logic [4:0] rs2;
    logic       rs2_used;
    logic       raw_stall;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       err;

    typedef struct {
        string name;
        int    cyc;
        int    cnt;
        bit    fl;
        bit    em;
        bit    st;
        bit    er;
    } exp_t;

    exp_t expQ[$];
    int   cyc    = 0;
    int   nPass  = 0;
    int   nTotal = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    witf_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .push_en   (push_en),
        .push_rd   (push_rd),
        .pop_en    (pop_en),
        .flush     (flush),
        .rs1       (rs1),
        .rs1_used  (rs1_used),
        .rs2       (rs2),
        .rs2_used  (rs2_used),
        .raw_stall (raw_stall),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .err       (err)
    );

    // Monitor: compare every expectation queued for the current cycle
    always @(negedge clk) begin
        exp_t e;
        while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            e = expQ.pop_front();
            nTotal++;
            if (e.cyc != cyc || int'(count) != e.cnt || full !== e.fl ||
                empty !== e.em || raw_stall !== e.st || err !== e.er) begin
                $display("FAIL %s: got count=%0d full=%b empty=%b stall=%b err=%b, want count=%0d full=%b empty=%b stall=%b err=%b",
                         e.name, count, full, empty, raw_stall, err,
                         e.cnt, e.fl, e.em, e.st, e.er);
            end else begin
                nPass++;
            end
        end
    end

    task automatic drive(input logic pe, input logic [4:0] prd, input logic po, input logic fl,
                         input logic [4:0] r1, input logic r1u, input logic [4:0] r2, input logic r2u);
        push_en  = pe;
        push_rd  = prd;
        pop_en   = po;
        flush    = fl;
        rs1      = r1;
        rs1_used = r1u;
        rs2      = r2;
        rs2_used = r2u;
    endtask

    task automatic expectNow(input string nm, input int c, input bit f, input bit e,
                             input bit s, input bit er);
        expQ.push_back('{nm, cyc, c, f, e, s, er});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        expectNow("reset", 0, 0, 1, 0, 0);
        tick();

        // Fill three entries, then hazard queries
        drive(1, 5, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 6, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 7, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 6, 1, 0, 0); expectNow("hit_rs1_6", 3, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 8, 1, 0, 0); expectNow("miss_rs1_8", 3, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0, 5, 1); expectNow("pop_cycle_rs2_5", 3, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 5, 1); expectNow("after_pop_rs2_5", 2, 0, 0, 0, 0); tick();

        // Fill, swap while full, then overflow
        drive(1, 8, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 2, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 9, 1, 0, 9, 1, 0, 0); expectNow("full_before_swap", 4, 1, 0, 0, 0); tick();
        drive(1, 10, 0, 0, 9, 1, 0, 0); expectNow("swap_rs1_9", 4, 1, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 10, 1, 0, 0); expectNow("overflow_dropped", 4, 1, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 6, 1, 7, 1); expectNow("survivors", 4, 1, 0, 1, 1); tick();

        // Reset clears sticky error
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        expectNow("reset2", 0, 0, 1, 0, 0); tick();

        // x0 handling and pop on empty
        drive(1, 0, 0, 0, 0, 1, 0, 0); expectNow("x0_query", 0, 0, 1, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0, 0, 0); expectNow("x0_ignored", 0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); expectNow("pop_empty_err", 0, 0, 1, 0, 1); tick();

        // WAW: stall persists until every copy is popped
        drive(1, 3, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 3, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 3, 1, 0, 0); expectNow("waw_two", 2, 0, 0, 1, 1); tick();
        drive(0, 0, 1, 0, 3, 1, 0, 0); expectNow("waw_one", 1, 0, 0, 1, 1); tick();
        drive(0, 0, 0, 0, 3, 1, 0, 0); expectNow("waw_clear", 0, 0, 1, 0, 1); tick();

        // Flush wins over simultaneous push and pop
        drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 2, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 11, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 4, 1, 1, 4, 1, 0, 0); expectNow("pre_flush", 3, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 4, 1, 0, 0); expectNow("post_flush", 0, 0, 1, 0, 1); tick();

        // Wrap-around: steady push/pop keeps two entries in flight
        for (int i = 0; i < 10; i++) begin
            drive(1, 5'(20 + i), (i >= 2), 0, (i >= 2) ? 5'(18 + i) : 5'd19, 1, 0, 0);
            expectNow($sformatf("wrap%0d", i), (i == 0) ? 0 : ((i == 1) ? 1 : 2),
                      0, (i == 0), (i >= 2), 1);
            tick();
        end
        drive(0, 0, 1, 0, 29, 1, 0, 0); expectNow("drain1", 2, 0, 0, 1, 1); tick();
        drive(0, 0, 1, 0, 29, 1, 0, 0); expectNow("drain2", 1, 0, 0, 1, 1); tick();
        drive(0, 0, 0, 0, 29, 1, 0, 0); expectNow("drained", 0, 0, 1, 0, 1); tick();

        // Let the monitor catch up, bounded
        for (int k = 0; k < 5 && expQ.size() > 0; k++) @(negedge clk);
        if (expQ.size() > 0) begin
            $display("FAIL monitor_drain: got %0d pending expectations, want 0", expQ.size());
            nTotal += expQ.size();
        end
        #1;
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
